// File: rtl/afe_tot_multi.sv
// Purpose : multi-channel time-over-threshold capture of the first comparator pulse
//           per injection window, plus an SPI slave for readout and a GPIO register.
// Latency : 2-FF synchroniser + 1 registered transition (HIT 3 CLK after COMP rise);
//           MISO moves 3-4 CLK after an SCLK fall.
// Backpressure: none; the SPI master paces reads, channels count free-running.
//
// Ports:
//   CLK, RST            single clock, synchronous active-high reset
//   INJ_IN / INJ_OUT    injection window in, combinational pass-through out
//   COMP[N_CH]          async comparator outputs; HIT[N_CH] per-channel hit, LED = |HIT
//   SCLK, CS_B, MOSI    SPI mode-0 slave inputs (oversampled); MISO serial read data
//   GPIO[8]             register loaded with the last 8 MOSI bits of a frame
module afe_tot_multi #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            INJ_IN,
  input  logic [N_CH-1:0] COMP,
  output logic [N_CH-1:0] HIT,
  output logic            INJ_OUT,
  input  logic            SCLK,
  input  logic            CS_B,
  input  logic            MOSI,
  output logic            MISO,
  output logic [7:0]      GPIO,
  output logic            LED
);

  localparam int FRAME_W = N_CH * (CNT_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, COUNT, DONE} state_t;

  // ---------------------------------------------------------------- synchronisers
  logic            inj_s1, inj_s;
  logic [N_CH-1:0] comp_s1, comp_s;
  logic            sclk_s1, sclk_s, sclk_d;
  logic            cs_s1, cs_s, cs_d;
  logic            mosi_s1, mosi_s;

  // cs syncs reset low: if CS_B is still asserted when RST drops, no falling
  // edge is seen, so an aborted frame cannot restart half-way through.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inj_s1  <= 1'b0;  inj_s   <= 1'b0;
      comp_s1 <= '0;    comp_s  <= '0;
      sclk_s1 <= 1'b0;  sclk_s  <= 1'b0;  sclk_d <= 1'b0;
      cs_s1   <= 1'b0;  cs_s    <= 1'b0;  cs_d   <= 1'b0;
      mosi_s1 <= 1'b0;  mosi_s  <= 1'b0;
    end else begin
      inj_s1  <= INJ_IN;   inj_s  <= inj_s1;
      comp_s1 <= COMP;     comp_s <= comp_s1;
      sclk_s1 <= SCLK;     sclk_s <= sclk_s1;  sclk_d <= sclk_s;
      cs_s1   <= CS_B;     cs_s   <= cs_s1;    cs_d   <= cs_s;
      mosi_s1 <= MOSI;     mosi_s <= mosi_s1;
    end
  end

  logic cs_fall, cs_rise, sclk_fall, sclk_rise;
  assign cs_fall   =  cs_d   & ~cs_s;
  assign cs_rise   = ~cs_d   &  cs_s;
  assign sclk_fall =  sclk_d & ~sclk_s;
  assign sclk_rise = ~sclk_d &  sclk_s;

  // ---------------------------------------------------------------- TOT channels
  state_t           st  [N_CH];
  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]  ovf;

  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_CH; i++) begin
      if (RST || !inj_s) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
        ovf[i] <= 1'b0;
      end else begin
        case (st[i])
          IDLE:  st[i] <= ARMED;
          ARMED: if (comp_s[i]) begin
                   st[i]  <= COUNT;
                   cnt[i] <= {{(CNT_W-1){1'b0}}, 1'b1};
                 end
          COUNT: if (comp_s[i]) begin
                   if (cnt[i] == CNT_MAX) ovf[i] <= 1'b1;
                   else                   cnt[i] <= cnt[i] + 1'b1;
                 end else begin
                   st[i] <= DONE;
                 end
          default: st[i] <= DONE;  // DONE holds until the window closes
        endcase
      end
    end
  end

  logic [N_CH-1:0] hit;
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_CH; i++) hit[i] = (st[i] == COUNT) || (st[i] == DONE);
  end

  assign HIT     = hit;
  assign LED     = |hit;
  assign INJ_OUT = INJ_IN;

  // ---------------------------------------------------------------- SPI slave
  // Snapshot layout, MSB first on the wire: cnt[0] .. cnt[N_CH-1], ovf[N_CH-1:0].
  logic [FRAME_W-1:0] snap;
  always_comb begin
    snap = '0;
    for (int i = 0; i < N_CH; i++) snap[FRAME_W-1-i*CNT_W -: CNT_W] = cnt[i];
    snap[N_CH-1:0] = ovf;
  end

  logic [FRAME_W-1:0] sr_out;
  logic [7:0]         sr_in;
  logic [3:0]         bit_cnt;   // saturates at 8
  logic               frame_ok;  // set only by a cs fall seen outside reset
  logic [7:0]         gpio;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sr_out   <= '0;
      sr_in    <= '0;
      bit_cnt  <= '0;
      frame_ok <= 1'b0;
      gpio     <= '0;
    end else if (cs_fall) begin
      sr_out   <= snap;
      bit_cnt  <= '0;
      frame_ok <= 1'b1;
    end else if (cs_rise) begin
      // Clearing sr_out keeps leftovers of a short frame off MISO next time.
      sr_out   <= '0;
      frame_ok <= 1'b0;
      if (frame_ok && bit_cnt == 4'd8) gpio <= sr_in;
    end else if (!cs_s && frame_ok) begin
      // Zeros shift in behind the frame, so MISO reads 0 once it is exhausted.
      if (sclk_fall) sr_out <= {sr_out[FRAME_W-2:0], 1'b0};
      if (sclk_rise) begin
        sr_in <= {sr_in[6:0], mosi_s};
        if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  assign MISO = ~cs_s & sr_out[FRAME_W-1];
  assign GPIO = gpio;

endmodule

// File: doc/afe_tot_multi.md
# afe_tot_multi

Multi-channel time-over-threshold (TOT) front-end controller for the AFE board CPLD. It measures the TOT of the first comparator pulse on each of N_CH channels inside an injection window, with saturation and overflow flags. It also passes the injection strobe through and provides an SPI slave that reads all channel results in one frame while writing the 8-bit GPIO register. All logic runs on CLK; SPI and analog inputs are synchronised and oversampled.

## Interface
- N_CH, default 4: number of comparator channels (1..8).
- CNT_W, default 8: TOT counter width per channel (4..12).
- CLK  in  1  system clock; the only clock in the block (BUFG-driven).
- RST  in  1  synchronous reset, active-high.
- INJ_IN  in  1  injection window, shared by all channels; low clears the measurement.
- COMP  in  N_CH  asynchronous comparator outputs, one bit per channel.
- HIT  out  N_CH  per-channel hit flag.
- INJ_OUT  out  1  combinational pass-through of INJ_IN.
- SCLK  in  1  SPI clock, mode 0, at most CLK/8.
- CS_B  in  1  SPI chip select, active-low.
- MOSI  in  1  SPI data in, MSB first.
- MISO  out  1  SPI data out, MSB first.
- GPIO  out  8  GPIO register written over SPI.
- LED  out  1  OR of HIT.

## Operation
- One clock; reset is synchronous and active-high.
- Synchronisers:
  - INJ_IN, COMP[i], SCLK, CS_B and MOSI each pass through a 2-FF synchroniser (inj_s, comp_s[i], sclk_s, cs_s, mosi_s).
  - Edge detectors on sclk_s and cs_s use one further register.
- Per-channel FSM, with states IDLE, ARMED, COUNT and DONE. Priority is RST, then !inj_s, then the transitions below.
  - Any state with !inj_s: go to IDLE, cnt=0, ovf=0.
  - IDLE with inj_s: go to ARMED.
  - ARMED with comp_s[i]: go to COUNT, cnt=1.
  - COUNT with comp_s[i]: cnt = cnt+1, saturating at 2^CNT_W-1. An increment attempted at the maximum sets ovf=1, which stays set until IDLE.
  - COUNT with !comp_s[i]: go to DONE.
  - DONE: hold cnt and ovf. Further COMP pulses are ignored until INJ_IN goes low.
  - cnt therefore equals the number of CLK cycles that comp_s[i] was high during the first pulse.
- HIT[i] = 1 in COUNT or DONE.
- SPI frame:
  - Frame length FRAME_W = N_CH*(CNT_W+1) bits.
  - On the cs_s falling edge, the shift register snapshots {cnt[0], cnt[1], ..., cnt[N_CH-1], ovf[N_CH-1:0]}. Each cnt is MSB first. ovf bit N_CH-1 is sent first within the ovf field.
  - MISO presents the first bit from the snapshot cycle onward.
  - Each sclk_s falling edge while cs_s=0 shifts out the next bit.
  - After FRAME_W bits, MISO outputs 0.
  - MISO=0 while cs_s=1.
  - Channels keep counting during a frame; the snapshot is not affected.
- SPI write:
  - Each sclk_s rising edge while cs_s=0 shifts mosi_s into an 8-bit sr_in and increments a saturating bit counter.
  - On the cs_s rising edge, GPIO <= sr_in only if the bit counter is 8 or more, so the last 8 bits win. Otherwise GPIO is unchanged.
  - The bit counter clears on the cs_s falling edge.
- Reset values:
  - HIT, GPIO, MISO and LED are 0.
  - All counters and ovf are 0; all FSMs are in IDLE.
  - The SPI shift registers and bit counter are 0.
  - INJ_OUT follows INJ_IN, including during reset.

## Timing
- Input-to-state latency is 2 CLK cycles (synchroniser) plus 1 cycle for the registered transition.
  - HIT rises 3 CLK cycles after a COMP rising edge.
  - A reset triggered by INJ_IN falling takes effect 3 cycles after the edge.
- TOT resolution is 1 CLK cycle. A pulse lasting k cycles yields cnt=k, with ±1 for asynchronous phase.
- Pulse-width limits:
  - A pulse shorter than 1 CLK cycle may be missed.
  - A pulse that overlaps INJ_IN falling is discarded.
- SPI timing:
  - MISO updates 3 to 4 CLK cycles after the SCLK falling edge.
  - With SCLK at most CLK/8, MISO is stable before the master's rising-edge sample.
  - Minimum SCLK high and low times are 4 CLK each. CS_B high between frames is at least 4 CLK.
- RST mid-frame aborts the frame: MISO goes to 0 and GPIO is not updated by the following CS_B rise. The bit counter is cleared.
- RST and a cs_s edge in the same cycle: RST wins.

## Test plan
- Reset: after RST=1 for 2 cycles with all inputs active → HIT=0, GPIO=0x00, MISO=0, LED=0; INJ_OUT tracks INJ_IN.
- Single pulse (N_CH=4, CNT_W=8): INJ_IN=1, then COMP[2] high for 37 CLK → HIT=4'b0100 three cycles after the rising edge. An SPI read gives cnt[2]=37, the other counts 0, and all ovf=0.
- Saturation (CNT_W=4): COMP[0] high for 40 CLK → cnt[0]=15, ovf[0]=1. A second pulse in the same window leaves cnt[0] at 15. INJ_IN low then high clears both to 0.
- Multi-channel and first-pulse-only: COMP[0]=10 cycles, COMP[1]=20 cycles, COMP[3] two pulses of 5 and 9 cycles → read gives 10, 20, 0 and 5.
- GPIO write: 12-bit frame 0xFA5 → GPIO=0xA5. A 5-bit frame → GPIO unchanged. Mid-frame RST → GPIO=0x00.
- SPI snapshot isolation: a read starts while COMP[1] is counting → the frame returns the value at the CS_B fall, and a following read returns the final count.
